// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared FSM state, access-size encodings and latency bound for the memory port
package mem_access_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam int MAX_MEM_LATENCY = 7;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: sub-word store lane replication, byte enables and load extraction
module mem_lane_align import mem_access_pkg::*; (
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] wdata_lane,
  output logic [3:0]  be,
  output logic [31:0] rdata_ext
);
  logic [31:0] sh;
  assign sh = rdata >> {off, 3'b000};
  assign wdata_lane = size == SZ_BYTE ? {4{wdata[7:0]}} : size == SZ_HALF ? {2{wdata[15:0]}} : wdata;
  assign be = size == SZ_BYTE ? 4'b0001 << off : size == SZ_HALF ? 4'b0011 << off : 4'b1111;
  assign rdata_ext = size == SZ_BYTE ? {{24{sext & sh[7]}}, sh[7:0]} :
                     size == SZ_HALF ? {{16{sext & sh[15]}}, sh[15:0]} : rdata;
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: valid/ready memory port to a fixed-latency SRAM with alignment/range checks; MEM_SUBWORD_EN adds byte/half accesses
module mem_access_unit import mem_access_pkg::*; #(
  parameter int DEPTH = 1024,
  parameter int AW = $clog2(DEPTH),
  parameter int MEM_LATENCY = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
`ifdef MEM_SUBWORD_EN
  ,
  input  logic [1:0]    req_size,
  input  logic          req_sext,
  output logic [3:0]    mem_be
`endif
);
  localparam int CW = $clog2(MAX_MEM_LATENCY + 1);
  state_t state;
  logic wr, err;
  logic [AW-1:0] idx, addr_q;
  logic [31:0] wdata, wdata_q, wr_data, rd_data;
  logic [CW-1:0] cnt;
`ifdef MEM_SUBWORD_EN
  logic [1:0] size, off;
  logic sext;
  logic [3:0] be;
  assign err = req_size == 2'd3 || (req_size == SZ_HALF && req_addr[0]) ||
               (req_size == SZ_WORD && req_addr[1:0] != 2'b00) || req_addr[31:2] >= 30'(DEPTH);
  mem_lane_align u_align (
    .size(size), .sext(sext), .off(off), .wdata(wdata), .rdata(mem_rdata),
    .wdata_lane(wr_data), .be(be), .rdata_ext(rd_data)
  );
  assign mem_be = mem_we ? be : 4'b0000;
`else
  assign err = req_addr[1:0] != 2'b00 || req_addr[31:2] >= 30'(DEPTH);
  assign wr_data = wdata;
  assign rd_data = mem_rdata;
`endif
  assign req_ready = state == IDLE;
  assign rsp_valid = state == RESP;
  assign mem_en = state == ISSUE;
  assign mem_we = mem_en && wr;
  assign mem_addr = mem_en ? idx : addr_q;
  assign mem_wdata = mem_en ? wr_data : wdata_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      wr <= 1'b0;
      idx <= '0;
      wdata <= '0;
      cnt <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
`ifdef MEM_SUBWORD_EN
      size <= SZ_WORD;
      sext <= 1'b0;
      off <= 2'b00;
`endif
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          wr <= req_write;
          idx <= req_addr[AW+1:2];
          wdata <= req_wdata;
          rsp_err <= err;
`ifdef MEM_SUBWORD_EN
          size <= req_size;
          sext <= req_sext;
          off <= req_addr[1:0];
`endif
          state <= err ? RESP : ISSUE;
        end
        ISSUE: begin
          addr_q <= mem_addr;
          wdata_q <= mem_wdata;
          cnt <= CW'(MEM_LATENCY - 1);
          state <= wr ? RESP : WAIT;
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            rsp_rdata <= rd_data;
            state <= RESP;
          end
        end
        RESP: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of the memory port at latencies 1 and 3 against behavioural SRAMs
module tb_mem_access_unit;
  logic clock, reset, v1, v3, s, req_write, req_sext;
  logic [31:0] req_addr, req_wdata;
  logic [1:0] req_size;
  logic rdy1, rv1, re1, en1, we1, rdy3, rv3, re3, en3, we3;
  logic [31:0] rd1, wd1, mr1, rd3, wd3, mr3;
  logic [9:0] a1, a3;
  logic [3:0] be1, be3;
  logic [31:0] m1 [0:1023];
  logic [31:0] m3 [0:1023];
  logic [31:0] p1;
  logic [31:0] p3 [0:2];
  logic o_ready, o_rv, o_err, o_en, o_we;
  logic [31:0] o_rd, o_wd;
  logic [9:0] o_addr;
  logic [3:0] o_be;
  int checks = 0, errors = 0;

  mem_access_unit #(.MEM_LATENCY(1)) u1 (
    .clock(clock), .reset(reset), .req_valid(v1), .req_ready(rdy1), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(re1),
    .mem_en(en1), .mem_we(we1), .mem_addr(a1), .mem_wdata(wd1), .mem_rdata(mr1)
`ifdef MEM_SUBWORD_EN
    , .req_size(req_size), .req_sext(req_sext), .mem_be(be1)
`endif
  );
  mem_access_unit #(.MEM_LATENCY(3)) u3 (
    .clock(clock), .reset(reset), .req_valid(v3), .req_ready(rdy3), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv3), .rsp_rdata(rd3), .rsp_err(re3),
    .mem_en(en3), .mem_we(we3), .mem_addr(a3), .mem_wdata(wd3), .mem_rdata(mr3)
`ifdef MEM_SUBWORD_EN
    , .req_size(req_size), .req_sext(req_sext), .mem_be(be3)
`endif
  );
`ifndef MEM_SUBWORD_EN
  assign be1 = 4'hF;
  assign be3 = 4'hF;
`endif

  assign mr1 = p1;
  assign mr3 = p3[2];
  assign o_ready = s ? rdy3 : rdy1;
  assign o_rv = s ? rv3 : rv1;
  assign o_err = s ? re3 : re1;
  assign o_en = s ? en3 : en1;
  assign o_we = s ? we3 : we1;
  assign o_rd = s ? rd3 : rd1;
  assign o_wd = s ? wd3 : wd1;
  assign o_addr = s ? a3 : a1;
  assign o_be = s ? be3 : be1;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    for (int k = 0; k < 4; k++) if (be[k]) o[8*k +: 8] = n[8*k +: 8];
    return o;
  endfunction

  always @(posedge clock) begin
    if (en1 && we1) m1[a1] <= merge(m1[a1], wd1, be1);
    if (en1 && !we1) p1 <= m1[a1];
    if (en3 && we3) m3[a3] <= merge(m3[a3], wd3, be3);
    p3[0] <= (en3 && !we3) ? m3[a3] : p3[0];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic txn(input logic sel, input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [1:0] size, input logic sext, input int exp_lat, input logic exp_err,
                     input logic [31:0] exp_rd, input logic [31:0] exp_mw, input logic [3:0] exp_be,
                     input string tag);
    int lat, en_n;
    lat = 0;
    en_n = 0;
    @(negedge clock);
    s = sel;
    req_write = wr;
    req_addr = addr;
    req_wdata = wd;
    req_size = size;
    req_sext = sext;
    chk({tag, "_ready"}, o_ready, 1);
    if (sel) v3 = 1; else v1 = 1;
    @(posedge clock);
    #1 v1 = 0;
    v3 = 0;
    for (int i = 1; i <= 12 && lat == 0; i++) begin
      @(negedge clock);
      if (o_en) en_n++;
      if (i == 1 && !exp_err) begin
        chk({tag, "_issue_en"}, o_en, 1);
        chk({tag, "_issue_we"}, o_we, wr);
        chk({tag, "_issue_addr"}, o_addr, addr[11:2]);
        if (wr) chk({tag, "_issue_wdata"}, o_wd, exp_mw);
`ifdef MEM_SUBWORD_EN
        chk({tag, "_issue_be"}, o_be, exp_be);
`endif
      end
      if (o_rv) begin
        lat = i;
        chk({tag, "_err"}, o_err, exp_err);
        chk({tag, "_rdata"}, o_rd, exp_rd);
      end
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_mem_en_count"}, en_n, exp_err ? 0 : 1);
  endtask

  initial begin
    int n;
    for (int k = 0; k < 1024; k++) begin
      m1[k] = 0;
      m3[k] = 0;
    end
    p1 = 0;
    for (int k = 0; k < 3; k++) p3[k] = 0;
    s = 0; v1 = 0; v3 = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_size = 2'd2; req_sext = 0;
    reset = 1;
    repeat (2) @(negedge clock);
    chk("rst_ready", rdy1, 1);
    chk("rst_rsp_valid", rv1, 0);
    chk("rst_err", re1, 0);
    chk("rst_rdata", rd1, 0);
    chk("rst_mem_en", en1, 0);
    chk("rst_mem_we", we1, 0);
    chk("rst_mem_addr", a1, 0);
    chk("rst_mem_wdata", wd1, 0);
    chk("rst_mem_be", o_be, 4'hF & {4{1'b1}} & ((be1 === 4'hF) ? 4'hF : 4'h0));
    reset = 0;
    txn(0, 1, 32'h10, 32'hDEADBEEF, 2'd2, 0, 2, 0, 32'h0, 32'hDEADBEEF, 4'hF, "wr10_l1");
    txn(1, 1, 32'h10, 32'hDEADBEEF, 2'd2, 0, 2, 0, 32'h0, 32'hDEADBEEF, 4'hF, "wr10_l3");
    txn(0, 0, 32'h10, 32'h0, 2'd2, 0, 3, 0, 32'hDEADBEEF, 32'h0, 4'h0, "rd10_l1");
    txn(1, 0, 32'h10, 32'h0, 2'd2, 0, 5, 0, 32'hDEADBEEF, 32'h0, 4'h0, "rd10_l3");
    chk("hold_mem_addr", a1, 10'd4);
    txn(0, 1, 32'h20, 32'h12345678, 2'd2, 0, 2, 0, 32'hDEADBEEF, 32'h12345678, 4'hF, "wr20");
    chk("hold_mem_wdata", wd1, 32'h12345678);
    txn(0, 0, 32'h12, 32'h0, 2'd2, 0, 1, 1, 32'hDEADBEEF, 32'h0, 4'h0, "rd_misaligned");
    txn(0, 0, 32'h1000, 32'h0, 2'd2, 0, 1, 1, 32'hDEADBEEF, 32'h0, 4'h0, "rd_range");
    txn(0, 1, 32'h1000, 32'hBAD0BAD0, 2'd2, 0, 1, 1, 32'hDEADBEEF, 32'h0, 4'h0, "wr_range");
    txn(0, 0, 32'h80000010, 32'h0, 2'd2, 0, 1, 1, 32'hDEADBEEF, 32'h0, 4'h0, "rd_high_addr");
    txn(0, 1, 32'hFFC, 32'hCAFEF00D, 2'd2, 0, 2, 0, 32'hDEADBEEF, 32'hCAFEF00D, 4'hF, "wr_last");
    txn(0, 0, 32'hFFC, 32'h0, 2'd2, 0, 3, 0, 32'hCAFEF00D, 32'h0, 4'h0, "rd_last");
    txn(0, 0, 32'h0, 32'h0, 2'd2, 0, 3, 0, 32'h0, 32'h0, 4'h0, "rd_nowrap");
    @(negedge clock);
    s = 0;
    req_write = 0;
    req_addr = 32'h10;
    v1 = 1;
    chk("b2b_first_ready", rdy1, 1);
    @(posedge clock);
    #1 req_addr = 32'h20;
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock);
      chk("b2b_ready", rdy1, (i == 4 || i >= 8) ? 1 : 0);
      if (rv1) begin
        n++;
        chk("b2b_rdata", rd1, n == 1 ? 32'hDEADBEEF : 32'h12345678);
        chk("b2b_rsp_cycle", i, n == 1 ? 3 : 7);
      end
      if (i == 4) begin
        @(posedge clock);
        #1 v1 = 0;
      end
    end
    chk("b2b_rsp_count", n, 2);
`ifdef MEM_SUBWORD_EN
    txn(0, 1, 32'h13, 32'h00000080, 2'd0, 0, 2, 0, 32'h12345678, 32'h80808080, 4'b1000, "sb13");
    txn(0, 0, 32'h13, 32'h0, 2'd0, 1, 3, 0, 32'hFFFFFF80, 32'h0, 4'h0, "lb13_sext");
    txn(0, 0, 32'h13, 32'h0, 2'd0, 0, 3, 0, 32'h00000080, 32'h0, 4'h0, "lb13_zext");
    txn(0, 0, 32'h12, 32'h0, 2'd1, 1, 3, 0, 32'hFFFF80AD, 32'h0, 4'h0, "lh12_sext");
    txn(0, 0, 32'h11, 32'h0, 2'd1, 0, 1, 1, 32'hFFFF80AD, 32'h0, 4'h0, "lh11_misaligned");
    txn(0, 0, 32'h10, 32'h0, 2'd3, 0, 1, 1, 32'hFFFF80AD, 32'h0, 4'h0, "size3_err");
    txn(0, 1, 32'h22, 32'h0000ABCD, 2'd1, 0, 2, 0, 32'hFFFF80AD, 32'hABCDABCD, 4'b1100, "sh22");
    txn(0, 0, 32'h20, 32'h0, 2'd2, 0, 3, 0, 32'hABCD5678, 32'h0, 4'h0, "lw20_after_sh");
`endif
    @(negedge clock);
    s = 1;
    req_write = 0;
    req_addr = 32'h10;
    req_size = 2'd2;
    v3 = 1;
    @(posedge clock);
    #1 v3 = 0;
    @(negedge clock);
    chk("mid_issue_en", en3, 1);
    @(negedge clock);
    reset = 1;
    @(negedge clock);
    chk("mid_rst_rsp_valid", rv3, 0);
    chk("mid_rst_ready", rdy3, 1);
    chk("mid_rst_mem_en", en3, 0);
    chk("mid_rst_rdata", rd3, 0);
    chk("mid_rst_mem_addr", a3, 0);
    reset = 0;
    n = 0;
    repeat (6) begin
      @(negedge clock);
      if (rv3) n++;
    end
    chk("mid_rst_no_rsp", n, 0);
    txn(1, 0, 32'h10, 32'h0, 2'd2, 0, 5, 0, 32'hDEADBEEF, 32'h0, 4'h0, "rd10_after_rst");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory port for the multicycle CPU datapath; all instruction fetches and load/store accesses go through it.
- Accepts one word-addressed request at a time over a valid/ready handshake.
- Drives a synchronous single-port SRAM with fixed read latency, then returns read data or a completion with an error flag.
- Checks byte address alignment and range before any memory access.

Parameters:
- DEPTH, 1024, memory size in 32-bit words.
- AW, $clog2(DEPTH), word-address width on the memory side.
- MEM_LATENCY, 1, cycles from the mem_en cycle to valid mem_rdata; legal range is 1..7.

Ports:
- clock  in  1  sole clock; rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present; held stable until accepted.
- req_ready  out  1  unit can accept a request.
- req_write  in  1  1 = store, 0 = fetch/load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  read data; held until the next response.
- rsp_err  out  1  valid with rsp_valid; set for misaligned or out-of-range access.
- mem_en  out  1  SRAM access strobe.
- mem_we  out  1  SRAM write enable.
- mem_addr  out  AW  SRAM word index, req_addr[AW+1:2].
- mem_wdata  out  32  SRAM write data.
- mem_rdata  in  32  SRAM read data, valid MEM_LATENCY cycles after the mem_en cycle.

Behaviour:
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch write, addr and wdata.
  - Error check: addr[1:0]!=0 or addr[31:2]>=DEPTH → go to RESP with err=1, no SRAM access. Otherwise → go to ISSUE.
- ISSUE:
  - Exactly one cycle, with mem_en=1, mem_we=latched write, mem_addr and mem_wdata from the latch.
  - Write → RESP.
  - Read → WAIT with counter loaded to MEM_LATENCY-1.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter is 0, capture mem_rdata into rsp_rdata and go to RESP.
  - With MEM_LATENCY=1, capture happens in the first WAIT cycle.
- RESP:
  - rsp_valid=1 for exactly one cycle, then return to IDLE.
  - rsp_rdata is updated only on reads.
  - Writes and errors leave rsp_rdata unchanged; an error read returns the previous rsp_rdata.
- req_ready is 1 only in IDLE; a requester presenting req_valid in any other state is stalled.
- Latency, counted as cycles from the accepting edge to the rsp_valid cycle:
  - read: MEM_LATENCY+2 (3 at default).
  - write: 2.
  - error: 1.
- Throughput: a new request can be accepted in the cycle after rsp_valid.
- mem_en and mem_we are 0 in every state except ISSUE.
- mem_addr and mem_wdata hold their last values outside ISSUE.
- Reset in mid-operation:
  - Immediate return to IDLE with all outputs at their reset values.
  - Pending read data is discarded and no rsp_valid is produced.
  - A write already strobed in ISSUE stays committed in the SRAM.
- Address wrap: addresses at or above DEPTH*4 are errors. Index bits are never truncated into range.

Optional Feature:
- Macro: MEM_SUBWORD_EN.
- With the macro defined, these ports are added:
  - req_size in 2: 0 = byte, 1 = half, 2 = word, 3 = illegal.
  - req_sext in 1: sign-extend loads.
  - mem_be out 4: byte-lane write enables.
- Alignment rules with the macro:
  - half requires addr[0]=0.
  - word requires addr[1:0]=0.
  - size=3 is an error.
- Stores with the macro:
  - Data is replicated across lanes: byte → {4{b}}, half → {2{h}}.
  - mem_be selects the target lanes: byte → 1<<addr[1:0], half → 4'b0011<<addr[1:0], word → 4'b1111.
- Loads with the macro: the selected lane(s) are extracted, right-justified, then sign- or zero-extended per req_sext before capture into rsp_rdata.
- Reset value of mem_be is 0; mem_be is 0 outside ISSUE and on reads.
- Without the macro: the extra ports are absent, and all accesses are word-only with a full-word write.

Decomposition:
- Shared package mem_access_pkg holds:
  - state enum {IDLE, ISSUE, WAIT, RESP}.
  - size encodings SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2.
  - MAX_MEM_LATENCY=7.
- Sub-module mem_lane_align is instantiated only under MEM_SUBWORD_EN. It is combinational and handles lane steering, be generation and load extraction.
- The FSM, the latch and the error check stay in mem_access_unit.

Test Plan:
- Reset, then write addr 0x10 wdata 0xDEADBEEF → ISSUE with mem_addr=4, mem_we=1; rsp_valid 2 cycles after accept, rsp_err=0.
- Read addr 0x10 with MEM_LATENCY=1 → rsp_valid 3 cycles after accept, rsp_rdata=0xDEADBEEF; then repeat with MEM_LATENCY=3 → 5 cycles.
- Read addr 0x12 (misaligned) and read addr 0x1000 (DEPTH=1024) → rsp_valid 1 cycle after accept, rsp_err=1, mem_en never asserted, rsp_rdata unchanged.
- req_valid held high across two back-to-back reads → req_ready=0 while busy, second request accepted in the cycle after the first rsp_valid, with no lost or duplicated response.
- reset asserted in WAIT of a read → next cycle IDLE with rsp_valid=0 and no response; a subsequent read of the same address still returns the stored data.
- MEM_SUBWORD_EN: store byte 0x80 to addr 0x13 → mem_be=4'b1000; load byte addr 0x13 with req_sext=1 → 0xFFFFFF80; with req_sext=0 → 0x00000080.
